tetris_input_rng: RTL and testbench
===================================

TETRIS_INPUT_RNG -- requirements
Module: tetris_input_rng

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, meaning: consecutive synchronized samples a button must hold a new level before the debounced level changes (legal range 2..255).
REQ-002 Parameter LFSR_SEED, default 8'h01, meaning: LFSR value loaded at reset and on lock-up recovery (must be nonzero).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 down_btn, right_btn, left_btn, rotate_btn  input  1 each  raw asynchronous push-button levels, active-high.
REQ-006 down_signal, right_signal, left_signal, rotate_signal  output  1 each  registered one-cycle press pulses.
REQ-007 random  output  8  current LFSR state, registered.
REQ-008 random_piece  output  3  piece index 0..6 derived from random.
REQ-009 random_rotate  output  2  rotation index derived from random.

Function
REQ-010 Each button SHALL have an identical, independent channel: 2-flop synchronizer, debounce counter (8 bits), debounced level "stable", registered pulse output.
REQ-011 Per clock: if sync2 == stable, counter SHALL clear to 0; else if counter == DEBOUNCE_CYCLES-1, stable SHALL take sync2 and counter SHALL clear; else counter SHALL increment.
REQ-012 The pulse output SHALL be 1 for exactly the one cycle following the edge where stable changes 0->1, and 0 at all other times; stable 1->0 SHALL produce no pulse.
REQ-013 Latency: if edge k is the first edge where sync1 captures 1 and the input stays high, stable SHALL rise and the pulse SHALL be asserted at edge k+DEBOUNCE_CYCLES+1 (k+5 at default).
REQ-014 A held button SHALL produce one pulse only; a new pulse requires release (debounced) and re-press.
REQ-015 An input level held fewer than DEBOUNCE_CYCLES synchronized cycles SHALL produce no pulse and leave stable unchanged.
REQ-016 Channels SHALL be independent; simultaneous presses SHALL yield simultaneous pulses (no priority in this block).
REQ-017 LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1; every clock (not reset) next = {random[6:0], random[7]^random[5]^random[4]^random[3]}.
REQ-018 If random == 8'h00 at a clock edge, the LFSR SHALL load LFSR_SEED instead of shifting.
REQ-019 Sequence from 8'h01 SHALL be 01, 02, 04, 08, 11, 23, 47, ...; period SHALL be 255.
REQ-020 random_piece SHALL be 3'd1 when random[2:0] == 3'b111, else random[2:0] (combinational).
REQ-021 random_rotate SHALL equal random[7:6] (combinational).

Reset
REQ-022 While reset is high at a clock edge: synchronizer flops, stable, counters and all pulse outputs SHALL be 0; random SHALL be LFSR_SEED.
REQ-023 Reset asserted mid-debounce SHALL discard the pending count; no pulse SHALL be emitted for that press unless it is re-qualified after reset deassertion.
REQ-024 First edge after reset deassertion SHALL advance random from LFSR_SEED (01 -> 02 at default).

Structure
REQ-025 Shared package SHALL hold: default DEBOUNCE_CYCLES, default LFSR_SEED, LFSR tap constant, piece-index width (3) and rotation width (2).
REQ-026 One sub-module, btn_debounce_pulse (one channel), SHALL be instantiated four times; the LFSR and piece decode SHALL be inline in tetris_input_rng.

Verification
REQ-027 Reset, then down_btn high and held for 20 cycles -> down_signal high for exactly one cycle, at edge k+5; other pulses 0.
REQ-028 right_btn glitch high for 3 cycles, then low -> right_signal never asserted; no state change.
REQ-029 left_btn and rotate_btn raised in same cycle, held 10 cycles, released 10, re-pressed 10 -> two single-cycle pulses on each, coincident.
REQ-030 Reset then free-run 256 cycles -> random sequence starts 01,02,04,08,11,23,47; never 00; value repeats after exactly 255 steps.
REQ-031 Force random = 8'h07 and 8'hC7 -> random_piece = 1, random_rotate = 0 and 3 respectively; random = 8'h05 -> random_piece = 5.
REQ-032 Assert reset 2 cycles into a debounce of up_btn-equivalent press (down_btn) -> no pulse; random returns to 01; press re-qualifies 5 edges after reset release.

Source files
------------

// File: rtl/tetris_input_rng_pkg.sv
// tetris_input_rng_pkg: shared defaults, LFSR taps and piece/rotation decode for the input/RNG block.
package tetris_input_rng_pkg;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam logic [7:0] LFSR_SEED_DEF = 8'h01;
  // Feedback bits 7,5,4,3 realise x^8+x^6+x^5+x^4+1 for a left-shifting Fibonacci LFSR.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam int unsigned PIECE_W = 3;
  localparam int unsigned ROT_W = 2;
  function automatic logic [PIECE_W-1:0] piece_of(input logic [7:0] r);
    return (r[2:0] == 3'b111) ? 3'd1 : r[2:0];
  endfunction
endpackage

// File: rtl/tetris_input_rng_if.sv
// tetris_input_rng_if: raw buttons in, press pulses and random outputs back.
interface tetris_input_rng_if;
  import tetris_input_rng_pkg::*;
  logic down_btn, right_btn, left_btn, rotate_btn;
  logic down_signal, right_signal, left_signal, rotate_signal;
  logic [7:0] random;
  logic [PIECE_W-1:0] random_piece;
  logic [ROT_W-1:0] random_rotate;
  modport master (
    output down_btn, right_btn, left_btn, rotate_btn,
    input down_signal, right_signal, left_signal, rotate_signal, random, random_piece, random_rotate
  );
  modport slave (
    input down_btn, right_btn, left_btn, rotate_btn,
    output down_signal, right_signal, left_signal, rotate_signal, random, random_piece, random_rotate
  );
endinterface

// File: rtl/tetris_input_rng_debounce.sv
// btn_debounce_pulse: one button channel -- synchronize, debounce, emit a one-cycle press pulse.
module btn_debounce_pulse
  import tetris_input_rng_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);
  logic sync1_q, sync2_q, stable_q, stable_d, pulse_q, pulse_d, flip, done;
  logic [7:0] cnt_q, cnt_d;
  always_comb begin
    flip = sync2_q != stable_q;
    done = cnt_q == 8'(DEBOUNCE_CYCLES - 1);
    cnt_d = (!flip || done) ? 8'd0 : cnt_q + 8'd1;
    stable_d = (flip && done) ? sync2_q : stable_q;
    pulse_d = flip && done && sync2_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      stable_q <= 1'b0;
      cnt_q <= 8'd0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      stable_q <= stable_d;
      cnt_q <= cnt_d;
      pulse_q <= pulse_d;
    end
  end
  assign pulse = pulse_q;
endmodule

// File: rtl/tetris_input_rng.sv
// tetris_input_rng: four debounced button pulse channels plus an 8-bit LFSR piece/rotation source.
module tetris_input_rng
  import tetris_input_rng_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic [7:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input logic clk,
  input logic reset,
  tetris_input_rng_if.slave io
);
  logic [7:0] random_q, random_d;
  btn_debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (.clk(clk), .reset(reset), .btn(io.down_btn), .pulse(io.down_signal));
  btn_debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (.clk(clk), .reset(reset), .btn(io.right_btn), .pulse(io.right_signal));
  btn_debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (.clk(clk), .reset(reset), .btn(io.left_btn), .pulse(io.left_signal));
  btn_debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rotate (.clk(clk), .reset(reset), .btn(io.rotate_btn), .pulse(io.rotate_signal));
  // An all-zero state would lock the LFSR, so it reloads the seed instead.
  always_comb random_d = (random_q == 8'h00) ? LFSR_SEED : {random_q[6:0], ^(random_q & LFSR_TAPS)};
  always_ff @(posedge clk) begin
    if (reset) random_q <= LFSR_SEED;
    else random_q <= random_d;
  end
  assign io.random = random_q;
  assign io.random_piece = piece_of(random_q);
  assign io.random_rotate = random_q[7:6];
endmodule

// File: tb/tb_tetris_input_rng.sv
// tb_tetris_input_rng: directed checks of debounce timing, pulse shape, reset and LFSR sequence.
module tb_tetris_input_rng;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  tetris_input_rng_if io ();
  tetris_input_rng dut (.clk(clk), .reset(reset), .io(io.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, {io.down_signal, io.right_signal, io.left_signal, io.rotate_signal}, 4'b0000);
  endtask

  logic [7:0] model;
  logic [7:0] first_seq [7];
  int ones_seen;
  int left_cnt, rot_cnt;

  initial begin
    first_seq[0] = 8'h01; first_seq[1] = 8'h02; first_seq[2] = 8'h04; first_seq[3] = 8'h08;
    first_seq[4] = 8'h11; first_seq[5] = 8'h23; first_seq[6] = 8'h47;
    io.down_btn = 0; io.right_btn = 0; io.left_btn = 0; io.rotate_btn = 0;
    tick(); tick();
    chk_quiet("reset_pulses");
    chk("reset_random", io.random, 8'h01);
    chk("reset_piece", io.random_piece, 3'd1);
    reset = 0;

    // LFSR free run
    ones_seen = 0;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (i < 7) chk($sformatf("seq_%0d", i), io.random, first_seq[i]);
      chk($sformatf("nonzero_%0d", i), io.random != 8'h00, 1'b1);
      if (io.random == 8'h01) ones_seen++;
      if (io.random == 8'h07) begin
        chk("piece_07", io.random_piece, 3'd1);
        chk("rot_07", io.random_rotate, 2'd0);
      end
      if (io.random == 8'hC7) begin
        chk("piece_C7", io.random_piece, 3'd1);
        chk("rot_C7", io.random_rotate, 2'd3);
      end
      if (io.random == 8'h05) chk("piece_05", io.random_piece, 3'd5);
    end
    chk("period_255", io.random, 8'h01);
    chk("seed_once_in_period", ones_seen, 1);
    // full sequence against an independent step model
    model = io.random;
    for (int i = 0; i < 40; i++) begin
      model = {model[6:0], model[7] ^ model[5] ^ model[4] ^ model[3]};
      tick();
      chk($sformatf("model_%0d", i), io.random, model);
      chk($sformatf("rot_model_%0d", i), io.random_rotate, model[7:6]);
    end

    // down press held 20 cycles: pulse after edge k+5 only
    reset = 1; tick(); reset = 0;
    io.down_btn = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("down_hold_%0d", i), io.down_signal, i == 5);
      chk($sformatf("down_others_%0d", i), {io.right_signal, io.left_signal, io.rotate_signal}, 3'b000);
    end
    io.down_btn = 0;
    repeat (8) tick();

    // 3-cycle glitch on right never qualifies
    io.right_btn = 1;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) io.right_btn = 0;
      tick();
      chk($sformatf("right_glitch_%0d", i), io.right_signal, 1'b0);
    end

    // left+rotate simultaneous press, release, re-press
    left_cnt = 0; rot_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      io.left_btn = (i < 10) || (i >= 20 && i < 30);
      io.rotate_btn = io.left_btn;
      tick();
      left_cnt += int'(io.left_signal);
      rot_cnt += int'(io.rotate_signal);
      chk($sformatf("left_%0d", i), io.left_signal, (i == 5) || (i == 25));
      chk($sformatf("coincident_%0d", i), io.rotate_signal, io.left_signal);
    end
    chk("left_count", left_cnt, 2);
    chk("rotate_count", rot_cnt, 2);
    repeat (8) tick();

    // reset two cycles into a down debounce
    io.down_btn = 1;
    tick(); tick();
    chk("pre_reset_quiet", io.down_signal, 1'b0);
    reset = 1;
    tick();
    chk("mid_reset_pulse", io.down_signal, 1'b0);
    chk("mid_reset_random", io.random, 8'h01);
    tick();
    chk("mid_reset_hold_pulse", io.down_signal, 1'b0);
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) chk("post_reset_random", io.random, 8'h02);
      chk($sformatf("requalify_%0d", i), io.down_signal, i == 5);
    end
    io.down_btn = 0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
